// File: rtl/pe_csa_mode.sv
// Systolic processing element with a runtime-selectable dataflow.
// WS mode chains a carry-save partial sum through the PE with one cycle of
// latency. OS mode accumulates a*b locally in carry-save form, then resolves
// the sum into a double-buffered result register behind a valid/ready port.
//
// Result port handshake: o_res is offered while o_res_valid=1 and is
// transferred on any clock edge where o_res_valid=1 and i_res_ready=1.
// o_res and o_res_valid do not depend on i_res_ready combinationally. A new
// resolve in the same cycle as a transfer replaces the value with no gap.
module pe_csa_mode #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24,
    parameter int K_MAX     = 256,
    parameter int SIGNED    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_mode,
    input  logic                     i_valid,
    input  logic                     i_last,
    input  logic [WIDTH-1:0]         i_z_a,
    input  logic [WIDTH-1:0]         i_x_b,
    input  logic [2*ACC_WIDTH-1:0]   i_y_p,
    output logic [WIDTH-1:0]         o_z_a,
    output logic [WIDTH-1:0]         o_x_b,
    output logic                     o_valid,
    output logic [2*ACC_WIDTH-1:0]   o_y_p,
    output logic                     o_y_valid,
    output logic [ACC_WIDTH-1:0]     o_res,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic                     o_busy,
    output logic                     o_err
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(K_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(K_MAX);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_ACC  = 1'b1;

    // Carry-save 3:2 compression, returned as {sum, carry}.
    function automatic logic [2*ACC_WIDTH-1:0] csa3(
        input logic [ACC_WIDTH-1:0] x,
        input logic [ACC_WIDTH-1:0] y,
        input logic [ACC_WIDTH-1:0] z
    );
        logic [ACC_WIDTH-1:0] s;
        logic [ACC_WIDTH-1:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {s, c};
    endfunction

    logic [PW-1:0]          a_ext;
    logic [PW-1:0]          b_ext;
    logic [PW-1:0]          prod;
    logic [ACC_WIDTH-1:0]   p;

    logic [0:0]             state;
    logic [0:0]             state_nxt;
    logic [ACC_WIDTH-1:0]   acc_s;
    logic [ACC_WIDTH-1:0]   acc_c;
    logic [ACC_WIDTH-1:0]   acc_s_nxt;
    logic [ACC_WIDTH-1:0]   acc_c_nxt;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          cnt_nxt;
    logic                   resolve;
    logic                   err_set;
    logic [ACC_WIDTH-1:0]   res_sum;
    logic [2*ACC_WIDTH-1:0] ws_csa;
    logic [2*ACC_WIDTH-1:0] os_csa;

    // Product: extending both operands to PW bits first makes the low PW bits
    // of an unsigned multiply equal to the signed or unsigned product.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext = {{WIDTH{i_z_a[WIDTH-1]}}, i_z_a};
            b_ext = {{WIDTH{i_x_b[WIDTH-1]}}, i_x_b};
        end else begin
            a_ext = {{WIDTH{1'b0}}, i_z_a};
            b_ext = {{WIDTH{1'b0}}, i_x_b};
        end
        prod = a_ext * b_ext;
    end

    // Fit the product to the accumulator width (extend or truncate).
    generate
        if (ACC_WIDTH > PW) begin : g_prod_extend
            logic ext_bit;
            assign ext_bit = (SIGNED != 0) & prod[PW-1];
            assign p = {{(ACC_WIDTH - PW){ext_bit}}, prod};
        end else begin : g_prod_trunc
            assign p = prod[ACC_WIDTH-1:0];
        end
    endgenerate

    assign ws_csa = csa3(i_y_p[2*ACC_WIDTH-1:ACC_WIDTH], i_y_p[ACC_WIDTH-1:0], p);
    assign os_csa = csa3(acc_s, acc_c, p);

    // OS accumulator next state, resolve strobe and error sources.
    always_comb begin
        state_nxt = state;
        acc_s_nxt = acc_s;
        acc_c_nxt = acc_c;
        cnt_nxt   = cnt;
        resolve   = 1'b0;
        err_set   = 1'b0;
        if (i_mode) begin
            if (i_valid) begin
                case (state)
                    ST_IDLE: begin
                        acc_s_nxt = p;
                        acc_c_nxt = '0;
                        cnt_nxt   = CNT_ONE;
                        if (i_last) begin
                            resolve = 1'b1;
                        end else begin
                            state_nxt = ST_ACC;
                        end
                    end
                    default: begin
                        {acc_s_nxt, acc_c_nxt} = os_csa;
                        if (cnt != CNT_MAX) begin
                            cnt_nxt = cnt + CNT_ONE;
                        end
                        if (!i_last && (cnt == CNT_MAX)) begin
                            err_set = 1'b1;
                        end
                        if (i_last) begin
                            resolve   = 1'b1;
                            state_nxt = ST_IDLE;
                        end
                    end
                endcase
            end
        end else if (state == ST_ACC) begin
            // Leaving OS mode mid-accumulation abandons it.
            state_nxt = ST_IDLE;
            acc_s_nxt = '0;
            acc_c_nxt = '0;
            cnt_nxt   = '0;
            err_set   = 1'b1;
        end
        res_sum = acc_s_nxt + acc_c_nxt;
    end

    assign o_busy = (state == ST_ACC);

    // Operand forwarding to neighbouring PEs, independent of mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_z_a   <= '0;
            o_x_b   <= '0;
            o_valid <= 1'b0;
        end else begin
            o_z_a   <= i_z_a;
            o_x_b   <= i_x_b;
            o_valid <= i_valid;
        end
    end

    // WS partial-sum register; forced to zero while in OS mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_y_p     <= '0;
            o_y_valid <= 1'b0;
        end else if (i_mode) begin
            o_y_p     <= '0;
            o_y_valid <= 1'b0;
        end else begin
            o_y_valid <= i_valid;
            if (i_valid) begin
                o_y_p <= ws_csa;
            end
        end
    end

    // OS accumulator state, counter and FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            acc_s <= '0;
            acc_c <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc_s <= acc_s_nxt;
            acc_c <= acc_c_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Result buffer with valid/ready handshake and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_res       <= '0;
            o_res_valid <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            if (resolve) begin
                o_res       <= res_sum;
                o_res_valid <= 1'b1;
            end else if (o_res_valid && i_res_ready) begin
                o_res_valid <= 1'b0;
            end
            if (err_set || (resolve && o_res_valid && !i_res_ready)) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pe_csa_mode.sv
// Bench for pe_csa_mode: directed scenarios plus a randomized run checked
// against an arithmetic reference model (integer sums, not carry-save).
module tb_pe_csa_mode;

    localparam int W  = 8;
    localparam int AW = 24;
    localparam int K  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_mode;
    logic            i_valid;
    logic            i_last;
    logic [W-1:0]    i_z_a;
    logic [W-1:0]    i_x_b;
    logic [2*AW-1:0] i_y_p;
    logic [W-1:0]    o_z_a;
    logic [W-1:0]    o_x_b;
    logic            o_valid;
    logic [2*AW-1:0] o_y_p;
    logic            o_y_valid;
    logic [AW-1:0]   o_res;
    logic            o_res_valid;
    logic            i_res_ready;
    logic            o_busy;
    logic            o_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [W-1:0]  m_za, m_xb;
    logic          m_valid, m_y_valid, m_busy, m_err, m_res_valid;
    logic [AW-1:0] m_y_sum, m_sum, m_res;
    int            m_cnt;

    logic [AW-1:0] y_sum;
    assign y_sum = o_y_p[2*AW-1:AW] + o_y_p[AW-1:0];

    pe_csa_mode #(.WIDTH(W), .ACC_WIDTH(AW), .K_MAX(K), .SIGNED(1)) dut (
        .clk(clk), .rst(rst), .i_mode(i_mode), .i_valid(i_valid),
        .i_last(i_last), .i_z_a(i_z_a), .i_x_b(i_x_b), .i_y_p(i_y_p),
        .o_z_a(o_z_a), .o_x_b(o_x_b), .o_valid(o_valid), .o_y_p(o_y_p),
        .o_y_valid(o_y_valid), .o_res(o_res), .o_res_valid(o_res_valid),
        .i_res_ready(i_res_ready), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // Advance the reference model by one clock using the current inputs.
    task automatic model_step();
        int pa, pb, pr;
        logic [AW-1:0] p;
        logic res_now;
        pa = int'($signed(i_z_a));
        pb = int'($signed(i_x_b));
        pr = pa * pb;
        p = AW'(pr);
        res_now = 1'b0;
        if (rst) begin
            m_za = '0; m_xb = '0; m_valid = 0; m_y_valid = 0; m_y_sum = '0;
            m_busy = 0; m_err = 0; m_res_valid = 0; m_res = '0; m_sum = '0; m_cnt = 0;
        end else begin
            m_za = i_z_a; m_xb = i_x_b; m_valid = i_valid;
            if (!i_mode) begin
                if (m_busy) begin
                    m_busy = 0; m_cnt = 0; m_sum = '0; m_err = 1;
                end
                m_y_valid = i_valid;
                if (i_valid) m_y_sum = i_y_p[2*AW-1:AW] + i_y_p[AW-1:0] + p;
            end else begin
                m_y_valid = 0;
                m_y_sum = '0;
                if (i_valid) begin
                    if (!m_busy) begin
                        m_sum = p;
                        m_cnt = 1;
                    end else begin
                        if (!i_last && m_cnt == K) m_err = 1;
                        m_sum = m_sum + p;
                        if (m_cnt < K) m_cnt++;
                    end
                    if (i_last) begin
                        m_busy = 0;
                        res_now = 1;
                    end else begin
                        m_busy = 1;
                    end
                end
            end
            if (res_now) begin
                if (m_res_valid && !i_res_ready) m_err = 1;
                m_res = m_sum;
                m_res_valid = 1;
            end else if (m_res_valid && i_res_ready) begin
                m_res_valid = 0;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        i_valid = 0; i_last = 0; i_res_ready = 0; i_y_p = '0;
        i_z_a = '0; i_x_b = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        i_mode = 1'($urandom_range(0, 1));
        tick();
        rst = 0;
        i_mode = 1;
        set_idle();
    endtask

    task automatic os_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic last, input logic ready);
        i_mode = 1; i_valid = 1; i_last = last; i_z_a = a; i_x_b = b;
        i_res_ready = ready;
        tick();
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            i_mode = 1'($urandom_range(0, 1)); i_valid = 1'($urandom_range(0, 1));
            i_last = 1'($urandom_range(0, 1)); i_res_ready = 1'($urandom_range(0, 1));
            i_z_a = W'($urandom); i_x_b = W'($urandom);
            i_y_p = {AW'($urandom), AW'($urandom)};
            tick();
        end
        n_checks++;
        if ({o_z_a, o_x_b, o_valid} !== '0) begin
            n_fail++; $display("FAIL reset_fwd: got %h/%h/%b expected 0", o_z_a, o_x_b, o_valid);
        end
        n_checks++;
        if ({o_y_p, o_y_valid} !== '0) begin
            n_fail++; $display("FAIL reset_ws: got %h/%b expected 0", o_y_p, o_y_valid);
        end
        n_checks++;
        if ({o_res, o_res_valid} !== '0) begin
            n_fail++; $display("FAIL reset_res: got %h/%b expected 0", o_res, o_res_valid);
        end
        rst = 0;
        i_mode = 1;
        set_idle();
        tick();
        n_checks++;
        if (o_busy !== 1'b0 || o_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_fsm: busy=%b err=%b expected 0/0", o_busy, o_err);
        end
    endtask

    task automatic test_ws_chain();
        do_reset();
        i_mode = 0; i_valid = 1; i_y_p = {24'd10, 24'd0};
        i_z_a = 8'hFD; i_x_b = 8'd5;
        tick();
        n_checks++;
        if (o_y_valid !== 1'b1 || y_sum !== 24'hFFFFFB) begin
            n_fail++; $display("FAIL ws_chain: valid=%b sum=%h expected 1/fffffb", o_y_valid, y_sum);
        end
        n_checks++;
        if (o_z_a !== 8'hFD || o_x_b !== 8'd5 || o_valid !== 1'b1) begin
            n_fail++; $display("FAIL ws_fwd: got %h/%h/%b expected fd/05/1", o_z_a, o_x_b, o_valid);
        end
        i_valid = 0; i_y_p = {24'd99, 24'd1};
        tick();
        n_checks++;
        if (o_y_valid !== 1'b0 || y_sum !== 24'hFFFFFB) begin
            n_fail++; $display("FAIL ws_hold: valid=%b sum=%h expected 0/fffffb", o_y_valid, y_sum);
        end
    endtask

    task automatic test_os_accumulate();
        int vcount;
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            os_beat(W'(k), 8'd2, (k == 4), 1'b1);
            if (k < 4) begin
                n_checks++;
                if (o_busy !== 1'b1) begin
                    n_fail++; $display("FAIL os_busy beat %0d: got %b expected 1", k + 1, o_busy);
                end
            end
        end
        n_checks++;
        if (o_res !== 24'd20 || o_res_valid !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL os_result: res=%0d valid=%b busy=%b expected 20/1/0",
                               o_res, o_res_valid, o_busy);
        end
        vcount = 1;
        set_idle();
        i_res_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (o_res_valid) vcount++;
        end
        n_checks++;
        if (vcount !== 1) begin
            n_fail++; $display("FAIL os_valid_pulse: got %0d cycles expected 1", vcount);
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        os_beat(8'd7, 8'd7, 1'b1, 1'b0);
        n_checks++;
        if (o_res !== 24'd49 || o_res_valid !== 1'b1 || o_err !== 1'b0) begin
            n_fail++; $display("FAIL bp_first: res=%0d valid=%b err=%b expected 49/1/0",
                               o_res, o_res_valid, o_err);
        end
        os_beat(8'd3, 8'd3, 1'b1, 1'b0);
        n_checks++;
        if (o_res !== 24'd9 || o_res_valid !== 1'b1 || o_err !== 1'b1) begin
            n_fail++; $display("FAIL bp_overrun: res=%0d valid=%b err=%b expected 9/1/1",
                               o_res, o_res_valid, o_err);
        end
        set_idle();
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (o_res !== 24'd9 || o_res_valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold: res=%0d valid=%b expected 9/1", o_res, o_res_valid);
        end
        i_res_ready = 1;
        tick();
        n_checks++;
        if (o_res_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_accept: valid=%b expected 0", o_res_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        os_beat(8'd2, 8'd3, 1'b1, 1'b0);
        os_beat(8'd4, 8'd5, 1'b1, 1'b1);
        n_checks++;
        if (o_res !== 24'd20 || o_res_valid !== 1'b1 || o_err !== 1'b0) begin
            n_fail++; $display("FAIL simul_accept: res=%0d valid=%b err=%b expected 20/1/0",
                               o_res, o_res_valid, o_err);
        end
        set_idle();
        i_res_ready = 1;
        tick();
        n_checks++;
        if (o_res_valid !== 1'b0) begin
            n_fail++; $display("FAIL simul_drain: valid=%b expected 0", o_res_valid);
        end
    endtask

    task automatic test_length_overflow();
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            os_beat(8'd1, 8'd1, 1'b0, 1'b1);
            if (k == 4) begin
                n_checks++;
                if (o_err !== 1'b0) begin
                    n_fail++; $display("FAIL len_at_max: err=%b expected 0", o_err);
                end
            end
        end
        n_checks++;
        if (o_err !== 1'b1) begin
            n_fail++; $display("FAIL len_over: err=%b expected 1", o_err);
        end
        os_beat(8'd1, 8'd1, 1'b1, 1'b1);
        n_checks++;
        if (o_res !== 24'd6 || o_res_valid !== 1'b1 || o_err !== 1'b1) begin
            n_fail++; $display("FAIL len_result: res=%0d valid=%b err=%b expected 6/1/1",
                               o_res, o_res_valid, o_err);
        end
    endtask

    task automatic test_mode_abort();
        do_reset();
        os_beat(8'd5, 8'd5, 1'b1, 1'b0);
        os_beat(8'd2, 8'd2, 1'b0, 1'b0);
        i_mode = 0; i_valid = 1; i_last = 0; i_z_a = 8'd3; i_x_b = 8'd4;
        i_y_p = {24'd1, 24'd1};
        tick();
        n_checks++;
        if (o_busy !== 1'b0 || o_err !== 1'b1) begin
            n_fail++; $display("FAIL abort_flags: busy=%b err=%b expected 0/1", o_busy, o_err);
        end
        n_checks++;
        if (o_y_valid !== 1'b1 || y_sum !== 24'd14) begin
            n_fail++; $display("FAIL abort_ws: valid=%b sum=%0d expected 1/14", o_y_valid, y_sum);
        end
        n_checks++;
        if (o_res !== 24'd25 || o_res_valid !== 1'b1) begin
            n_fail++; $display("FAIL abort_keep_res: res=%0d valid=%b expected 25/1",
                               o_res, o_res_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) i_mode = ~i_mode;
            i_valid = ($urandom_range(0, 3) != 0);
            i_last = ($urandom_range(0, 3) == 0);
            i_res_ready = 1'($urandom_range(0, 1));
            i_z_a = W'($urandom); i_x_b = W'($urandom);
            i_y_p = {AW'($urandom), AW'($urandom)};
            tick();
            n_checks++;
            if ({o_z_a, o_x_b, o_valid} !== {m_za, m_xb, m_valid}) begin
                n_fail++; $display("FAIL rnd_fwd cyc %0d: got %h/%h/%b expected %h/%h/%b",
                                   i, o_z_a, o_x_b, o_valid, m_za, m_xb, m_valid);
            end
            n_checks++;
            if (o_y_valid !== m_y_valid || y_sum !== m_y_sum) begin
                n_fail++; $display("FAIL rnd_ws cyc %0d: got %b/%h expected %b/%h",
                                   i, o_y_valid, y_sum, m_y_valid, m_y_sum);
            end
            n_checks++;
            if (o_res !== m_res || o_res_valid !== m_res_valid) begin
                n_fail++; $display("FAIL rnd_res cyc %0d: got %h/%b expected %h/%b",
                                   i, o_res, o_res_valid, m_res, m_res_valid);
            end
            n_checks++;
            if (o_busy !== m_busy || o_err !== m_err) begin
                n_fail++; $display("FAIL rnd_flags cyc %0d: busy/err got %b/%b expected %b/%b",
                                   i, o_busy, o_err, m_busy, m_err);
            end
        end
        rst = 0;
    endtask

    initial begin
        rst = 1; i_mode = 1;
        set_idle();
        test_reset();
        test_ws_chain();
        test_os_accumulate();
        test_back_pressure();
        test_back_to_back();
        test_length_overflow();
        test_mode_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_csa_mode.md
Name: pe_csa_mode

Overview:
- Next-generation systolic processing element for the cube array. Forwards the A/B operands to its neighbours and computes a*b into a carry-save accumulator.
- Runtime-selectable dataflow:
  - WS (weight-stationary chaining): partial sums flow through the PE in carry-save form, with a registered output.
  - OS (output-stationary): the PE accumulates locally, then resolves and presents one binary result through a valid/ready port.
- Adds valid tracking, accumulation-length checking and a double-buffered result. The predecessor PE had none of these.

Parameters:
- WIDTH, 8, operand width of A and B.
- ACC_WIDTH, 24, width of each accumulator half (sum and carry); all accumulation is modulo 2^ACC_WIDTH.
- K_MAX, 256, maximum OS accumulation length; the counter width is clog2(K_MAX+1).
- SIGNED, 1, operand interpretation: 1 means two's complement, 0 means unsigned.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_mode  in  1  0 = WS chaining, 1 = OS accumulate.
- i_valid  in  1  operands (and i_y_p in WS) valid this cycle.
- i_last  in  1  OS only: final operand pair of the current accumulation.
- i_z_a  in  WIDTH  operand A.
- i_x_b  in  WIDTH  operand B.
- i_y_p  in  2*ACC_WIDTH  incoming partial sum, {sum, carry}.
- o_z_a  out  WIDTH  registered copy of i_z_a.
- o_x_b  out  WIDTH  registered copy of i_x_b.
- o_valid  out  1  registered copy of i_valid (valid for the forwarded operands).
- o_y_p  out  2*ACC_WIDTH  WS partial-sum output, {sum, carry}.
- o_y_valid  out  1  o_y_p valid.
- o_res  out  ACC_WIDTH  resolved OS result.
- o_res_valid  out  1  o_res held for the consumer.
- i_res_ready  in  1  consumer accepts o_res.
- o_busy  out  1  OS accumulation in progress.
- o_err  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset: on a clk edge with rst=1, every output register and internal register goes to 0 and the FSM goes to IDLE. This includes o_err.
- Product: p = i_z_a*i_x_b (2*WIDTH bits, signed or unsigned per SIGNED), sign- or zero-extended to ACC_WIDTH (truncated if narrower).
- CSA3(x,y,z) is defined as:
  - s = x^y^z
  - c = ((x&y)|(x&z)|(y&z))<<1
  - both truncated to ACC_WIDTH.
- Forwarding: o_z_a, o_x_b and o_valid register their inputs every cycle, regardless of mode. Latency is 1.
- WS mode (i_mode=0):
  - {o_y_p sum, carry} <= CSA3(i_y_p[2*ACC_WIDTH-1:ACC_WIDTH], i_y_p[ACC_WIDTH-1:0], p) when i_valid.
  - o_y_valid <= i_valid. Latency is 1.
  - When i_valid=0, o_y_p holds its value.
- OS mode (i_mode=1), FSM states IDLE and ACC:
  - IDLE, i_valid=1:
    - acc <= {p, 0}; cnt <= 1.
    - If i_last=0, go to ACC.
    - If i_last=1, resolve immediately and stay in IDLE.
  - ACC, i_valid=1:
    - acc <= CSA3(acc_s, acc_c, p); cnt <= cnt+1.
    - If i_last=1, go to IDLE.
  - ACC, i_valid=0: hold.
  - o_busy = (state==ACC).
- Resolve (the same cycle i_last is accepted): o_res <= (next acc_s + next acc_c) mod 2^ACC_WIDTH; o_res_valid <= 1.
  - The accumulator and the result register are separate, so a new accumulation may start on the very next cycle.
- Result handshake:
  - o_res_valid clears on a cycle with o_res_valid & i_res_ready, unless a new resolve occurs in that same cycle. In that case o_res loads the new value and o_res_valid stays 1.
  - o_res is stable while o_res_valid=1 and i_res_ready=0.
- Overrun: a resolve while o_res_valid=1 and i_res_ready=0 overwrites o_res with the new value and sets o_err.
- Length overflow: i_valid with i_last=0 when cnt==K_MAX sets o_err. Accumulation continues modulo 2^ACC_WIDTH; cnt saturates at K_MAX.
- Mode change mid-operation: i_mode=0 while in ACC abandons the accumulation. acc and cnt clear, the FSM returns to IDLE and o_err is set. The operands of that cycle are processed as WS.
- In OS mode, o_y_p and o_y_valid hold 0. In WS mode, o_res and o_res_valid are unaffected (a pending result stays available).
- Reset mid-accumulation or mid-handshake: everything clears. The pending result is lost, and this is not flagged.

Test Plan:
- Reset: drive rst=1 for 2 cycles with random inputs, then rst=0 → every output is 0 and the FSM is IDLE.
- WS chain, SIGNED=1:
  - i_y_p={24'd10, 24'd0}, a=-3, b=5, i_valid=1.
  - Next cycle: o_y_valid=1 and o_y_p sum+carry mod 2^24 = -5 (0xFFFFFB); o_z_a=-3 and o_x_b=5 one cycle later.
- OS accumulate: a=1..4, b=2, i_last on the 4th beat, i_res_ready=1.
  - o_res_valid=1 for exactly 1 cycle, o_res=20, o_busy high during beats 2-4.
- Back-pressure/overrun:
  - Two length-1 accumulations on consecutive cycles (7*7, then 3*3) with i_res_ready=0.
  - Expected: o_res=49, then 9; o_err=1; o_res_valid stays 1 until ready.
- Simultaneous resolve and accept: i_res_ready=1 in the same cycle a new i_last arrives → o_res updates to the new value and o_res_valid remains 1 with no gap.
- Limit checks:
  - K_MAX=4, feed 5 non-last beats of 1*1 and then a last beat of 1*1 → o_err=1 and o_res=6.
  - Separately, toggle i_mode to 0 during ACC → o_err=1 and o_busy=0 the next cycle.
